sp_ram_arbiter: RTL and testbench

SP_RAM_ARBITER -- requirements
Module: sp_ram_arbiter

---
 rtl/sp_ram_arbiter.sv | 100 ++++++++++
 tb/tb_sp_ram_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/sp_ram_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port synchronous RAM.
// Grants are combinational; read data returns one cycle after the grant.
module sp_ram_arbiter #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              req0_rvalid,
  output logic [DATA_W-1:0] req0_rdata,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              req1_rvalid,
  output logic [DATA_W-1:0] req1_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] data_in,
  output logic              write_en,
  input  logic [DATA_W-1:0] data_out
);

  logic              last_q;
  logic              gnt0_c;
  logic              gnt1_c;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              rd0_q;
  logic              rd1_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;

  // Round-robin grant: last_q names the port granted most recently.
  always_comb begin
    gnt0_c = 1'b0;
    gnt1_c = 1'b0;
    if (!rst) begin
      if (req0_valid && req1_valid) begin
        gnt0_c = last_q;
        gnt1_c = ~last_q;
      end else begin
        gnt0_c = req0_valid;
        gnt1_c = req1_valid;
      end
    end
  end

  // RAM side: granted requester drives the bus, otherwise hold the last granted values.
  always_comb begin
    ram_addr = addr_q;
    data_in  = wdata_q;
    write_en = 1'b0;
    if (gnt0_c) begin
      ram_addr = req0_addr;
      data_in  = req0_wdata;
      write_en = req0_we;
    end else if (gnt1_c) begin
      ram_addr = req1_addr;
      data_in  = req1_wdata;
      write_en = req1_we;
    end
  end

  assign req0_ready  = gnt0_c;
  assign req1_ready  = gnt1_c;
  // A pending read flag is squashed while reset is asserted.
  assign req0_rvalid = rd0_q & ~rst;
  assign req1_rvalid = rd1_q & ~rst;
  assign req0_rdata  = req0_rvalid ? data_out : rdata0_q;
  assign req1_rdata  = req1_rvalid ? data_out : rdata1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q   <= 1'b1;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd0_q    <= 1'b0;
      rd1_q    <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      if (gnt0_c || gnt1_c) begin
        last_q  <= gnt1_c;
        addr_q  <= ram_addr;
        wdata_q <= data_in;
      end
      rd0_q <= gnt0_c & ~req0_we;
      rd1_q <= gnt1_c & ~req1_we;
      if (req0_rvalid) rdata0_q <= data_out;
      if (req1_rvalid) rdata1_q <= data_out;
    end
  end

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Directed bench for sp_ram_arbiter with a behavioural single-port RAM.
module tb_sp_ram_arbiter;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              req0_valid, req0_we, req0_ready, req0_rvalid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata, req0_rdata;
  logic              req1_valid, req1_we, req1_ready, req1_rvalid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata, req1_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] data_in, data_out;
  logic              write_en;
  logic [DATA_W-1:0] mem [2**ADDR_W];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Registered-output RAM: data_out reflects the address of the previous cycle.
  always @(posedge clk) begin
    if (write_en) mem[ram_addr] <= data_in;
    data_out <= mem[ram_addr];
  end

  sp_ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready), .req0_rvalid(req0_rvalid),
    .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready), .req1_rvalid(req1_rvalid),
    .req1_rdata(req1_rdata),
    .ram_addr(ram_addr), .data_in(data_in), .write_en(write_en), .data_out(data_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of stimulus just after the rising edge, then wait for the falling edge.
  task automatic cyc(input logic r,
                     input logic v0, input logic w0, input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                     input logic v1, input logic w1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1);
    @(posedge clk);
    #1;
    rst = r;
    req0_valid = v0; req0_we = w0; req0_addr = a0; req0_wdata = d0;
    req1_valid = v1; req1_we = w1; req1_addr = a1; req1_wdata = d1;
    @(negedge clk);
  endtask

  task automatic idle(input logic r);
    cyc(r, 1'b0, 1'b0, 6'd0, 8'h00, 1'b0, 1'b0, 6'd0, 8'h00);
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;

    // Reset state
    idle(1'b1);
    idle(1'b1);
    check("rst_ready0", 32'(req0_ready), 32'd0);
    check("rst_ready1", 32'(req1_ready), 32'd0);
    check("rst_we", 32'(write_en), 32'd0);
    check("rst_rvalid0", 32'(req0_rvalid), 32'd0);
    check("rst_rvalid1", 32'(req1_rvalid), 32'd0);
    check("rst_addr", 32'(ram_addr), 32'd0);
    check("rst_din", 32'(data_in), 32'd0);
    check("rst_rdata0", 32'(req0_rdata), 32'd0);
    check("rst_rdata1", 32'(req1_rdata), 32'd0);

    // Single-port writes on consecutive cycles
    cyc(1'b0, 1'b1, 1'b1, 6'd0, 8'h10, 1'b0, 1'b0, 6'd0, 8'h00);
    check("wr0_ready", 32'(req0_ready), 32'd1);
    check("wr0_we", 32'(write_en), 32'd1);
    check("wr0_addr", 32'(ram_addr), 32'd0);
    check("wr0_din", 32'(data_in), 32'h10);
    cyc(1'b0, 1'b1, 1'b1, 6'd2, 8'h11, 1'b0, 1'b0, 6'd0, 8'h00);
    check("wr1_ready", 32'(req0_ready), 32'd1);
    check("wr1_we", 32'(write_en), 32'd1);
    check("wr1_addr", 32'(ram_addr), 32'd2);
    cyc(1'b0, 1'b1, 1'b1, 6'd7, 8'h20, 1'b0, 1'b0, 6'd0, 8'h00);
    check("wr2_ready", 32'(req0_ready), 32'd1);
    check("wr2_we", 32'(write_en), 32'd1);
    check("wr2_addr", 32'(ram_addr), 32'd7);
    check("wr2_din", 32'(data_in), 32'h20);
    check("wr2_rvalid0", 32'(req0_rvalid), 32'd0);

    // Idle: outputs quiet, bus holds last granted values
    for (int i = 0; i < 5; i++) begin
      idle(1'b0);
      check("idle_we", 32'(write_en), 32'd0);
      check("idle_ready0", 32'(req0_ready), 32'd0);
      check("idle_ready1", 32'(req1_ready), 32'd0);
      check("idle_addr", 32'(ram_addr), 32'd7);
      check("idle_din", 32'(data_in), 32'h20);
    end

    // Readback on port 1, back-to-back
    cyc(1'b0, 1'b0, 1'b0, 6'd0, 8'h00, 1'b1, 1'b0, 6'd0, 8'h00);
    check("rd_ready1_a", 32'(req1_ready), 32'd1);
    check("rd_we_a", 32'(write_en), 32'd0);
    check("rd_rvalid1_a", 32'(req1_rvalid), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 6'd0, 8'h00, 1'b1, 1'b0, 6'd2, 8'h00);
    check("rd_rvalid1_b", 32'(req1_rvalid), 32'd1);
    check("rd_rdata1_b", 32'(req1_rdata), 32'h10);
    check("rd_rvalid0_b", 32'(req0_rvalid), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 6'd0, 8'h00, 1'b1, 1'b0, 6'd7, 8'h00);
    check("rd_rvalid1_c", 32'(req1_rvalid), 32'd1);
    check("rd_rdata1_c", 32'(req1_rdata), 32'h11);
    check("rd_rvalid0_c", 32'(req0_rvalid), 32'd0);
    idle(1'b0);
    check("rd_rvalid1_d", 32'(req1_rvalid), 32'd1);
    check("rd_rdata1_d", 32'(req1_rdata), 32'h20);
    check("rd_rvalid0_d", 32'(req0_rvalid), 32'd0);
    idle(1'b0);
    check("rd_rvalid1_e", 32'(req1_rvalid), 32'd0);
    check("rd_hold1_e", 32'(req1_rdata), 32'h20);

    // Contention right after reset: 0,1,0,1
    idle(1'b1);
    idle(1'b1);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 6'd0, 8'h00, 1'b1, 1'b0, 6'd2, 8'h00);
      check("arb_ready0", 32'(req0_ready), 32'((i % 2) == 0));
      check("arb_ready1", 32'(req1_ready), 32'((i % 2) == 1));
      if (i == 1) begin
        check("arb_rvalid0", 32'(req0_rvalid), 32'd1);
        check("arb_rdata0", 32'(req0_rdata), 32'h10);
      end
      if (i == 2) begin
        check("arb_rvalid1", 32'(req1_rvalid), 32'd1);
        check("arb_rdata1", 32'(req1_rdata), 32'h11);
      end
    end
    idle(1'b0);

    // Read-after-write across ports
    cyc(1'b0, 1'b1, 1'b1, 6'd5, 8'hA5, 1'b0, 1'b0, 6'd0, 8'h00);
    check("raw_we", 32'(write_en), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 6'd0, 8'h00, 1'b1, 1'b0, 6'd5, 8'h00);
    check("raw_ready1", 32'(req1_ready), 32'd1);
    idle(1'b0);
    check("raw_rvalid1", 32'(req1_rvalid), 32'd1);
    check("raw_rdata1", 32'(req1_rdata), 32'hA5);

    // Reset in the cycle after a granted read
    cyc(1'b0, 1'b1, 1'b0, 6'd7, 8'h00, 1'b0, 1'b0, 6'd0, 8'h00);
    check("rr_ready0", 32'(req0_ready), 32'd1);
    cyc(1'b1, 1'b1, 1'b1, 6'd3, 8'h77, 1'b1, 1'b1, 6'd4, 8'h66);
    check("rr_rvalid0_rst", 32'(req0_rvalid), 32'd0);
    check("rr_we_rst", 32'(write_en), 32'd0);
    check("rr_ready0_rst", 32'(req0_ready), 32'd0);
    check("rr_ready1_rst", 32'(req1_ready), 32'd0);
    idle(1'b0);
    check("rr_rvalid0_after", 32'(req0_rvalid), 32'd0);
    check("rr_rdata0_after", 32'(req0_rdata), 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 6'd5, 8'h00, 1'b1, 1'b0, 6'd0, 8'h00);
    check("rr_arb_ready0", 32'(req0_ready), 32'd1);
    check("rr_arb_ready1", 32'(req1_ready), 32'd0);
    idle(1'b0);
    check("rr_post_rvalid0", 32'(req0_rvalid), 32'd1);
    check("rr_post_rdata0", 32'(req0_rdata), 32'hA5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
